// File: rtl/exc_ctrl.sv
// Commit-stage exception/interrupt controller: detects events, issues one CP0 strobe, then redirects and flushes.
// Optional taken-exception counter is enabled by defining EXC_STATS_EN.
module exc_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ins_valid,
  input  logic [31:0] ins_pc,
  input  logic        ins_in_delay,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_eret,
  input  logic        is_mtc0,
  input  logic        is_teq,
  input  logic        teq_eq,
  input  logic [5:0]  ext_int,
  input  logic        timer_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_exc_addr,
  output logic [5:0]  int_i,
  output logic        exception,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] epc_pc,
  output logic        delay,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] exc_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, REDIRECT, DRAIN} state_t;

  state_t      state;
  logic [5:0]  sync_q [SYNC_STAGES];
  logic [2:0]  drain_cnt;
  logic        irq_pend;
  logic        event_d;
  logic        eret_d;
  logic [4:0]  code_d;
  logic        unused_status;

  assign unused_status = &{1'b0, cp0_status[31:16], cp0_status[9:2]};

  // External lines are asynchronous; timer_int already lives in this clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      int_i <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      int_i <= {sync_q[SYNC_STAGES-1][5] | timer_int, sync_q[SYNC_STAGES-1][4:0]};
    end
  end

  // An mtc0 at commit may be rewriting Status/Compare, so nothing is taken on that cycle.
  always_comb begin
    irq_pend = cp0_status[0] & ~cp0_status[1] & (|(int_i & cp0_status[15:10]));
    event_d  = 1'b0;
    eret_d   = 1'b0;
    code_d   = 5'd0;
    if (ins_valid && !stall_i && !is_mtc0) begin
      if (irq_pend) begin
        event_d = 1'b1;
        code_d  = 5'd0;
      end else if (is_syscall) begin
        event_d = 1'b1;
        code_d  = 5'd8;
      end else if (is_break) begin
        event_d = 1'b1;
        code_d  = 5'd9;
      end else if (is_teq && teq_eq) begin
        event_d = 1'b1;
        code_d  = 5'd13;
      end else if (is_eret) begin
        event_d = 1'b1;
        eret_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      drain_cnt      <= '0;
      exception      <= 1'b0;
      eret           <= 1'b0;
      cause          <= '0;
      epc_pc         <= '0;
      delay          <= 1'b0;
      busy           <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (event_d) begin
            state     <= ISSUE;
            exception <= 1'b1;
            eret      <= eret_d;
            cause     <= code_d;
            epc_pc    <= ins_in_delay ? (ins_pc - 32'd4) : ins_pc;
            delay     <= ins_in_delay;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state          <= REDIRECT;
          exception      <= 1'b0;
          eret           <= 1'b0;
          redirect_pc    <= cp0_exc_addr;
          redirect_valid <= 1'b1;
          flush          <= 1'b1;
        end
        REDIRECT: begin
          state          <= DRAIN;
          redirect_valid <= 1'b0;
          drain_cnt      <= 3'(FLUSH_CYCLES - 1);
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state <= IDLE;
            flush <= 1'b0;
            busy  <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          flush <= 1'b0;
        end
      endcase
    end
  end

`ifdef EXC_STATS_EN
  // Erets are returns, not taken exceptions, so they are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_count <= '0;
    end else if (state == ISSUE && !eret) begin
      exc_count <= exc_count + 32'd1;
    end
  end
`else
  assign exc_count = 32'h0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: CP0 strobes are scoreboarded, flush/redirect timing is checked inline.
module tb_exc_ctrl;

  localparam int SYNC_STAGES  = 2;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, ins_valid, ins_in_delay;
  logic [31:0] ins_pc;
  logic        is_syscall, is_break, is_eret, is_mtc0, is_teq, teq_eq;
  logic [5:0]  ext_int;
  logic        timer_int;
  logic [31:0] cp0_status, cp0_exc_addr;
  logic [5:0]  int_i;
  logic        exception, eret, delay, busy, flush, redirect_valid;
  logic [4:0]  cause;
  logic [31:0] epc_pc, redirect_pc, exc_count;

  typedef struct packed {
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] epc;
    logic        delay;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_count = 32'h0;
  logic        prev_exc = 1'b0;

  exc_ctrl #(.SYNC_STAGES(SYNC_STAGES), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ins_valid(ins_valid), .ins_pc(ins_pc),
    .ins_in_delay(ins_in_delay), .is_syscall(is_syscall), .is_break(is_break), .is_eret(is_eret),
    .is_mtc0(is_mtc0), .is_teq(is_teq), .teq_eq(teq_eq), .ext_int(ext_int), .timer_int(timer_int),
    .cp0_status(cp0_status), .cp0_exc_addr(cp0_exc_addr), .int_i(int_i), .exception(exception),
    .eret(eret), .cause(cause), .epc_pc(epc_pc), .delay(delay), .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  // Every CP0 strobe must match the oldest expectation and never repeat on back-to-back cycles.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exception) begin
        n_checks++;
        if (prev_exc) begin
          n_fail++;
          $display("[TB] FAIL exc_consecutive: exception high two cycles, required single-cycle");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL unexpected_strobe: cause=%0d epc=%h eret=%b, required no strobe", cause, epc_pc, eret);
        end else begin
          e = exp_q.pop_front();
          if ({eret, cause, epc_pc, delay} !== {e.eret, e.cause, e.epc, e.delay}) begin
            n_fail++;
            $display("[TB] FAIL strobe_fields: got eret=%b cause=%0d epc=%h delay=%b, required eret=%b cause=%0d epc=%h delay=%b",
                     eret, cause, epc_pc, delay, e.eret, e.cause, e.epc, e.delay);
          end
        end
      end
      prev_exc = exception;
    end else begin
      prev_exc = 1'b0;
    end
  end

  task automatic push_exp(input logic er, input logic [4:0] c, input logic [31:0] epc, input logic d);
    exp_t e;
    e.eret = er; e.cause = c; e.epc = epc; e.delay = d;
    exp_q.push_back(e);
`ifdef EXC_STATS_EN
    if (!er) exp_count = exp_count + 32'd1;
`endif
  endtask

  task automatic clear_ins();
    ins_valid = 0; ins_in_delay = 0; ins_pc = '0; stall_i = 0;
    is_syscall = 0; is_break = 0; is_eret = 0; is_mtc0 = 0; is_teq = 0; teq_eq = 0;
  endtask

  // Presents one instruction for the next rising edge; returns on the following falling edge.
  task automatic present(input logic [31:0] pc, input logic dly, input logic sys, input logic brk,
                         input logic er, input logic mtc0, input logic teq, input logic teqeq);
    ins_valid = 1; ins_pc = pc; ins_in_delay = dly; is_syscall = sys; is_break = brk;
    is_eret = er; is_mtc0 = mtc0; is_teq = teq; teq_eq = teqeq;
    @(negedge clk);
    clear_ins();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_timeout: busy=%b after 20 cycles, required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; ext_int = 6'h3F;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({int_i, exception, eret, cause, epc_pc, delay, busy, flush, redirect_valid, redirect_pc, exc_count} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: int_i=%h busy=%b flush=%b epc=%h, required all zero", int_i, busy, flush, epc_pc);
    end
    ext_int = '0;
    rst_n = 1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
  endtask

  task automatic test_syscall();
    cp0_status = 32'h1000FF01; cp0_exc_addr = 32'h00400004;
    push_exp(1'b0, 5'd8, 32'h00400100, 1'b0);
    present(32'h00400100, 0, 1, 0, 0, 0, 0, 0);
    n_checks++;
    if (exception !== 1'b1) begin n_fail++; $display("[TB] FAIL sys_strobe_latency: exception=%b, required 1", exception); end
    @(negedge clk);
    n_checks++;
    if ({exception, redirect_valid, flush, redirect_pc} !== {1'b0, 1'b1, 1'b1, 32'h00400004}) begin
      n_fail++;
      $display("[TB] FAIL sys_redirect: exc=%b rv=%b flush=%b pc=%h, required 0 1 1 00400004", exception, redirect_valid, flush, redirect_pc);
    end
    repeat (FLUSH_CYCLES) begin
      @(negedge clk);
      n_checks++;
      if ({redirect_valid, flush, busy} !== 3'b011) begin
        n_fail++;
        $display("[TB] FAIL sys_drain: rv=%b flush=%b busy=%b, required 0 1 1", redirect_valid, flush, busy);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({flush, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL sys_idle: flush=%b busy=%b, required 0 0", flush, busy); end
    n_checks++;
    if (exc_count !== exp_count) begin n_fail++; $display("[TB] FAIL sys_count: got %h, required %h", exc_count, exp_count); end
  endtask

  task automatic test_delay_break();
    push_exp(1'b0, 5'd9, 32'h00400204, 1'b1);
    present(32'h00400208, 1, 0, 1, 0, 0, 0, 0);
    wait_idle();
  endtask

  task automatic test_irq_vs_syscall();
    cp0_status = 32'h00000401; cp0_exc_addr = 32'h80000180;
    ext_int = 6'h01;
    repeat (SYNC_STAGES) @(negedge clk);
    n_checks++;
    if (int_i[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL sync_early: int_i[0]=%b, required 0", int_i[0]); end
    @(negedge clk);
    n_checks++;
    if (int_i[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL sync_latency: int_i[0]=%b, required 1", int_i[0]); end
    push_exp(1'b0, 5'd0, 32'h00400400, 1'b0);
    present(32'h00400400, 0, 1, 0, 0, 0, 0, 0);
    wait_idle();
    cp0_status = 32'h00000403;
    push_exp(1'b0, 5'd8, 32'h00400500, 1'b0);
    present(32'h00400500, 0, 1, 0, 0, 0, 0, 0);
    wait_idle();
    ext_int = '0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
  endtask

  task automatic test_eret_mtc0();
    cp0_status = 32'h00000401; cp0_exc_addr = 32'h00400600;
    push_exp(1'b1, 5'd0, 32'h80000200, 1'b0);
    present(32'h80000200, 0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if ({exception, eret} !== 2'b11) begin n_fail++; $display("[TB] FAIL eret_strobe: exc=%b eret=%b, required 1 1", exception, eret); end
    @(negedge clk);
    n_checks++;
    if ({exception, eret, redirect_pc} !== {2'b00, 32'h00400600}) begin
      n_fail++;
      $display("[TB] FAIL eret_redirect: exc=%b eret=%b pc=%h, required 0 0 00400600", exception, eret, redirect_pc);
    end
    wait_idle();
    ext_int = 6'h01;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    present(32'h00400700, 0, 0, 0, 0, 1, 0, 0);
    n_checks++;
    if ({exception, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL mtc0_block: exc=%b busy=%b, required 0 0", exception, busy); end
    push_exp(1'b0, 5'd0, 32'h00400704, 1'b0);
    present(32'h00400704, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (exception !== 1'b1) begin n_fail++; $display("[TB] FAIL mtc0_deferred_irq: exception=%b, required 1", exception); end
    wait_idle();
    ext_int = '0;
    repeat (SYNC_STAGES + 2) @(negedge clk);
  endtask

  task automatic test_stall_reset();
    cp0_status = 32'h1000FF01; cp0_exc_addr = 32'h00400004;
    stall_i = 1; ins_valid = 1; ins_pc = 32'h00400800; is_teq = 1; teq_eq = 1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({exception, busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL stall_block: exc=%b busy=%b, required 0 0", exception, busy); end
    end
    push_exp(1'b0, 5'd13, 32'h00400800, 1'b0);
    stall_i = 0;
    @(negedge clk);
    clear_ins();
    n_checks++;
    if (exception !== 1'b1) begin n_fail++; $display("[TB] FAIL teq_after_stall: exception=%b, required 1", exception); end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({flush, busy, redirect_valid} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL teq_in_drain: flush=%b busy=%b rv=%b, required 1 1 0", flush, busy, redirect_valid);
    end
    #1 rst_n = 0;
    exp_count = 32'h0;
    #1;
    n_checks++;
    if ({flush, busy, redirect_valid, exception, exc_count} !== {4'b0000, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL reset_abort: flush=%b busy=%b rv=%b exc=%b count=%h, required all 0", flush, busy, redirect_valid, exception, exc_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_timer();
    cp0_status = 32'h00008001; cp0_exc_addr = 32'h80000180;
    timer_int = 1;
    @(negedge clk);
    n_checks++;
    if (int_i[5] !== 1'b1) begin n_fail++; $display("[TB] FAIL timer_int_i: int_i[5]=%b, required 1", int_i[5]); end
    push_exp(1'b0, 5'd0, 32'h00400900, 1'b0);
    present(32'h00400900, 0, 0, 0, 0, 0, 0, 0);
    wait_idle();
    timer_int = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (exc_count !== exp_count) begin n_fail++; $display("[TB] FAIL timer_count: got %h, required %h", exc_count, exp_count); end
    cp0_exc_addr = 32'h00400904;
    push_exp(1'b1, 5'd0, 32'h80000200, 1'b0);
    present(32'h80000200, 0, 0, 0, 1, 0, 0, 0);
    wait_idle();
    n_checks++;
    if (exc_count !== exp_count) begin n_fail++; $display("[TB] FAIL eret_count: got %h, required %h", exc_count, exp_count); end
  endtask

  initial begin
    clear_ins();
    rst_n = 0; ext_int = '0; timer_int = 0; cp0_status = '0; cp0_exc_addr = '0;
    @(negedge clk);
    test_reset();
    test_syscall();
    test_delay_break();
    test_irq_vs_syscall();
    test_eret_mtc0();
    test_stall_reset();
    test_timer();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL missing_strobes: %0d pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
